mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the fetch stage (read-only) and the load/store unit (read/write).
- Sits between the fetch stage's cache address/data/valid interface and the memory.
- Fixed priority to load/store, with a starvation guard for fetch.
- Honours pipeline flush by discarding an in-flight fetch response.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_WAIT, 3, consecutive lost arbitrations after which a pending fetch request wins (range 1..15)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_n_i  input  1  reset, asynchronous, active-low
flush_i  input  1  pipeline flush; kills pending/in-flight fetch
if_req_i  input  1  fetch read request, held until if_gnt_o
if_addr_i  input  ADDR_W  fetch address
if_gnt_o  output  1  one-cycle grant pulse to fetch
if_rdata_o  output  DATA_W  fetch read data
if_valid_o  output  1  one-cycle pulse, if_rdata_o valid
ls_req_i  input  1  load/store request, held until ls_gnt_o
ls_we_i  input  1  1 = store, 0 = load
ls_addr_i  input  ADDR_W  load/store address
ls_wdata_i  input  DATA_W  store data
ls_gnt_o  output  1  one-cycle grant pulse to load/store
ls_rdata_o  output  DATA_W  load data
ls_valid_o  output  1  one-cycle pulse; load data valid, or store complete
mem_req_o  output  1  memory request, held until mem_ack_i
mem_we_o  output  1  memory write enable
mem_addr_o  output  ADDR_W  memory address
mem_wdata_o  output  DATA_W  memory write data
mem_rdata_i  input  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  input  1  memory completion, single cycle

Behaviour:
- Reset (async, rst_n_i=0):
  - State IDLE; starvation counter 0.
  - All outputs 0, including mem_req_o, both gnt, both valid and all data/address buses.
  - Takes effect immediately.
- Reset mid-transaction:
  - Abandons the access; no valid pulse afterwards.
  - Memory tolerates a dropped mem_req_o.
- States: IDLE, BUSY_IF, BUSY_LS, BUSY_DROP.
- IDLE arbitration, evaluated each cycle:
  - Fetch is eligible when if_req_i=1 and flush_i=0.
  - Both eligible, counter < MAX_WAIT: grant LS, counter +1.
  - Both eligible, counter = MAX_WAIT: grant IF.
  - Only one eligible: grant it.
  - Counter clears on any IF grant, or when if_req_i=0.
- Grant cycle N:
  - gnt pulse high in cycle N (combinational from IDLE + request).
  - Registered mem_req_o/mem_addr_o/mem_we_o/mem_wdata_o valid from N+1.
  - IF grants force mem_we_o=0.
  - Next state is BUSY_IF or BUSY_LS.
- BUSY_* states:
  - mem_* outputs held stable until mem_ack_i.
  - mem_req_o drops in the cycle after the ack cycle.
- Ack in cycle M:
  - rdata register loads mem_rdata_i.
  - Matching valid pulses in M+1.
  - State returns to IDLE in M+1.
  - Earliest next grant is M+1, so there is a 1-cycle bubble minimum. Minimum request-to-valid latency is 2 cycles (ack in N+1).
- Store: ls_valid_o pulses on completion; ls_rdata_o is unchanged.
- Requests are ignored outside IDLE.
- A request withdrawn before its grant is legal; no grant is issued.
- flush_i:
  - In BUSY_IF: move to BUSY_DROP. The memory access completes, but no if_valid_o is issued and if_rdata_o is unchanged.
  - In BUSY_DROP: no effect.
  - In the same cycle as mem_ack_i in BUSY_IF: the response is dropped.
  - No effect on LS.
- Data registers hold their last value when not loaded.
- Valid pulses are exactly one cycle.
- Never both gnt high; never both valid high.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Starvation counter and MAX_WAIT are unused.
  - Arbitration is round-robin: a 1-bit last-winner flag (reset = IF) gives the other requester priority on collision.
  - Single requesters are still granted immediately.
- Undefined: fixed LS priority with the MAX_WAIT starvation guard, as above.

Test Plan:
1. Lone fetch:
   - Stimulus: if_req_i=1, if_addr_i=0x0000_0040 at cycle 1; mem_ack_i at cycle 3 with rdata=0x1234_5678.
   - Response: if_gnt_o at 1, mem_req_o 2..3, if_valid_o at 4 with 0x1234_5678.
2. Collision:
   - Stimulus: both requests held continuously, each ack 1 cycle after mem_req_o, MAX_WAIT=3.
   - Response: grant order LS,LS,LS,IF,LS,LS,LS,IF.
   - With MEM_ARB_RR_EN: LS,IF,LS,IF.
3. Store:
   - Stimulus: ls_we_i=1, addr 0x100, wdata 0xDEAD_BEEF.
   - Response: mem_we_o=1, mem_wdata_o=0xDEAD_BEEF held until ack; ls_valid_o pulses once; ls_rdata_o unchanged.
4. Flush in flight:
   - Stimulus: fetch granted; flush_i pulsed during BUSY_IF; ack 2 cycles later.
   - Response: no if_valid_o; if_rdata_o keeps its old value; next IF grant is possible after return to IDLE.
5. Flush in IDLE:
   - Stimulus: if_req_i=1 and flush_i=1 in the same cycle, no LS request.
   - Response: no grant that cycle; grant the following cycle once flush_i=0.
6. Async reset:
   - Stimulus: rst_n_i low mid-cycle during BUSY_LS.
   - Response: mem_req_o=0 immediately; no ls_valid_o; IDLE after release; new requests served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side buses of mem_port_arbiter, plus the pipeline flush.
// slave = arbiter view, master = surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              flush_i;
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_gnt_o;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_valid_o;
   logic              ls_req_i;
   logic              ls_we_i;
   logic [ADDR_W-1:0] ls_addr_i;
   logic [DATA_W-1:0] ls_wdata_i;
   logic              ls_gnt_o;
   logic [DATA_W-1:0] ls_rdata_o;
   logic              ls_valid_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ack_i;

   modport slave (
      input  flush_i, if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
             mem_rdata_i, mem_ack_i,
      output if_gnt_o, if_rdata_o, if_valid_o, ls_gnt_o, ls_rdata_o, ls_valid_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output flush_i, if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
             mem_rdata_i, mem_ack_i,
      input  if_gnt_o, if_rdata_o, if_valid_o, ls_gnt_o, ls_rdata_o, ls_valid_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (read-only) and load/store; LS priority with a
// MAX_WAIT starvation guard for fetch, or round-robin when MEM_ARB_RR_EN is defined.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, BUSY_DROP} state_e;

   state_e            state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              ls_valid_q, ls_valid_d;
   logic              if_elig, ls_elig, gnt_if, gnt_ls;

`ifdef MEM_ARB_RR_EN
   logic last_ls_q, last_ls_d;
`else
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
   logic [3:0] cnt_q, cnt_d;
`endif

   // Grants are combinational and gated by reset so every output reads 0 while rst_n_i is low.
   always_comb begin
      if_elig = bus.if_req_i && !bus.flush_i;
      ls_elig = bus.ls_req_i;
      gnt_if  = 1'b0;
      gnt_ls  = 1'b0;
      if (rst_n_i && state_q == IDLE) begin
         if (if_elig && ls_elig) begin
`ifdef MEM_ARB_RR_EN
            gnt_if = last_ls_q;
`else
            gnt_if = (cnt_q >= MAX_WAIT_C);
`endif
            gnt_ls = !gnt_if;
         end else begin
            gnt_if = if_elig;
            gnt_ls = ls_elig;
         end
      end
   end

`ifdef MEM_ARB_RR_EN
   always_comb begin
      last_ls_d = last_ls_q;
      if (gnt_if)      last_ls_d = 1'b0;
      else if (gnt_ls) last_ls_d = 1'b1;
   end
`else
   always_comb begin
      cnt_d = cnt_q;
      if (!bus.if_req_i || gnt_if)  cnt_d = '0;
      else if (gnt_ls && if_elig)   cnt_d = cnt_q + 4'd1;
   end
`endif

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_valid_d  = 1'b0;
      ls_valid_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gnt_if) begin
               state_d    = BUSY_IF;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = bus.if_addr_i;
            end else if (gnt_ls) begin
               state_d     = BUSY_LS;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.ls_we_i;
               mem_addr_d  = bus.ls_addr_i;
               mem_wdata_d = bus.ls_wdata_i;
            end
         end
         BUSY_IF: begin
            // A flush coinciding with the ack still kills the response.
            if (bus.mem_ack_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (!bus.flush_i) begin
                  if_rdata_d = bus.mem_rdata_i;
                  if_valid_d = 1'b1;
               end
            end else if (bus.flush_i) begin
               state_d = BUSY_DROP;
            end
         end
         BUSY_LS: begin
            if (bus.mem_ack_i) begin
               state_d    = IDLE;
               mem_req_d  = 1'b0;
               ls_valid_d = 1'b1;
               if (!mem_we_q) ls_rdata_d = bus.mem_rdata_i;
            end
         end
         BUSY_DROP: begin
            if (bus.mem_ack_i) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         ls_valid_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_ls_q   <= 1'b0;
`else
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         if_valid_q  <= if_valid_d;
         ls_valid_q  <= ls_valid_d;
`ifdef MEM_ARB_RR_EN
         last_ls_q   <= last_ls_d;
`else
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign bus.if_gnt_o    = gnt_if;
   assign bus.ls_gnt_o    = gnt_ls;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.if_valid_o  = if_valid_q;
   assign bus.ls_rdata_o  = ls_rdata_q;
   assign bus.ls_valid_o  = ls_valid_q;
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model; a small memory model answers mem_req_o.
module tb_mem_port_arbiter;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          mem_lat  = 1;
   int          lat_cnt  = 1;
   logic [31:0] mem_model [logic [31:0]];
   logic [31:0] exp_if_rd = '0;
   logic [31:0] exp_ls_rd = '0;

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory: acks mem_lat cycles after mem_req_o rises; junk on mem_rdata_i when not acking.
   always @(posedge clk) begin
      #1;
      if (!rst_n || bus.mem_ack_i) begin
         bus.mem_ack_i   = 1'b0;
         bus.mem_rdata_i = $urandom;
         lat_cnt         = mem_lat;
      end else if (bus.mem_req_o) begin
         if (lat_cnt == 0) begin
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = mem_read(bus.mem_addr_o);
            if (bus.mem_we_o) mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
         end else begin
            lat_cnt--;
            bus.mem_rdata_i = $urandom;
         end
      end else begin
         lat_cnt         = mem_lat;
         bus.mem_rdata_i = $urandom;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.flush_i    = 1'b0;
      bus.if_req_i   = 1'b1;
      bus.if_addr_i  = 32'h44;
      bus.ls_req_i   = 1'b1;
      bus.ls_we_i    = 1'b1;
      bus.ls_addr_i  = 32'h88;
      bus.ls_wdata_i = 32'hFFFF_FFFF;
      #12;
      n_checks++;
      if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b00)
         $display("FAIL reset_gnt: got %b required 00", {bus.if_gnt_o, bus.ls_gnt_o});
      n_checks++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0)
         $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h required all 0",
                  bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
      n_checks++;
      if ({bus.if_valid_o, bus.ls_valid_o, bus.if_rdata_o, bus.ls_rdata_o} !== '0)
         $display("FAIL reset_resp: got ifv=%b lsv=%b ifrd=%h lsrd=%h required all 0",
                  bus.if_valid_o, bus.ls_valid_o, bus.if_rdata_o, bus.ls_rdata_o);
      n_fail += ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b00) ? 1 : 0;
      n_fail += ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) ? 1 : 0;
      n_fail += ({bus.if_valid_o, bus.ls_valid_o, bus.if_rdata_o, bus.ls_rdata_o} !== '0) ? 1 : 0;
      bus.if_req_i = 1'b0;
      bus.ls_req_i = 1'b0;
      bus.ls_we_i  = 1'b0;
      mid();
      rst_n = 1'b1;
      exp_if_rd = '0;
      exp_ls_rd = '0;
      tick();
   endtask

   task automatic test_lone_fetch();
      mem_model[32'h40] = 32'h1234_5678;
      mem_lat = 1;
      tick();
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h40;
      mid();
      n_checks++;
      if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL lone_fetch_gnt: got if/ls=%b required 10", {bus.if_gnt_o, bus.ls_gnt_o});
      end
      tick();
      bus.if_req_i = 1'b0;
      mid();
      n_checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h40 || bus.mem_we_o !== 1'b0 || bus.if_gnt_o !== 1'b0) begin
         n_fail++;
         $display("FAIL lone_fetch_mem: got req=%b addr=%h we=%b gnt=%b required 1/00000040/0/0",
                  bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o, bus.if_gnt_o);
      end
      tick();
      mid();
      n_checks++;
      if (bus.mem_req_o !== 1'b1 || bus.if_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL lone_fetch_ack_cycle: got req=%b valid=%b required 1/0", bus.mem_req_o, bus.if_valid_o);
      end
      tick();
      mid();
      n_checks++;
      if (bus.if_valid_o !== 1'b1 || bus.if_rdata_o !== 32'h1234_5678 || bus.mem_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL lone_fetch_valid: got valid=%b rdata=%h req=%b required 1/12345678/0",
                  bus.if_valid_o, bus.if_rdata_o, bus.mem_req_o);
      end
      tick();
      mid();
      n_checks++;
      if (bus.if_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL lone_fetch_pulse: got valid=%b required 0", bus.if_valid_o);
      end
      exp_if_rd = 32'h1234_5678;
      tick();
   endtask

   task automatic test_collision();
      string exp_order = "";
      string got_order = "";
      int    grants    = 0;
      int    both      = 0;
      mem_model[32'h200] = 32'hCAFE_0200;
      mem_model[32'h300] = 32'hCAFE_0300;
      mem_lat = 1;
      for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_RR_EN
         exp_order = {exp_order, (k % 2 == 1) ? "I" : "L"};
`else
         exp_order = {exp_order, (k % (MAX_WAIT + 1) == MAX_WAIT) ? "I" : "L"};
`endif
      end
      tick();
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h300;
      bus.ls_req_i  = 1'b1;
      bus.ls_we_i   = 1'b0;
      bus.ls_addr_i = 32'h200;
      for (int c = 0; c < 80 && grants < 8; c++) begin
         mid();
         if (bus.if_gnt_o && bus.ls_gnt_o) both++;
         if (bus.if_gnt_o === 1'b1) begin
            got_order = {got_order, "I"};
            grants++;
         end else if (bus.ls_gnt_o === 1'b1) begin
            got_order = {got_order, "L"};
            grants++;
         end
         tick();
      end
      bus.if_req_i = 1'b0;
      bus.ls_req_i = 1'b0;
      n_checks++;
      if (got_order != exp_order) begin
         n_fail++;
         $display("FAIL collision_order: got %s required %s", got_order, exp_order);
      end
      n_checks++;
      if (both != 0) begin
         n_fail++;
         $display("FAIL collision_both_gnt: got %0d cycles with both grants required 0", both);
      end
      tick(); tick(); tick();
      mid();
      exp_if_rd = 32'hCAFE_0300;
      exp_ls_rd = 32'hCAFE_0200;
      n_checks++;
      if (bus.if_rdata_o !== exp_if_rd || bus.ls_rdata_o !== exp_ls_rd) begin
         n_fail++;
         $display("FAIL collision_rdata: got if=%h ls=%h required if=%h ls=%h",
                  bus.if_rdata_o, bus.ls_rdata_o, exp_if_rd, exp_ls_rd);
      end
      tick();
   endtask

   task automatic test_store();
      int pulses = 0;
      int vcyc   = -1;
      int hold_bad = 0;
      mem_lat = 2;
      tick();
      bus.ls_req_i   = 1'b1;
      bus.ls_we_i    = 1'b1;
      bus.ls_addr_i  = 32'h100;
      bus.ls_wdata_i = 32'hDEAD_BEEF;
      mid();
      n_checks++;
      if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL store_gnt: got if/ls=%b required 01", {bus.if_gnt_o, bus.ls_gnt_o});
      end
      tick();
      bus.ls_req_i   = 1'b0;
      bus.ls_we_i    = 1'b0;
      bus.ls_addr_i  = 32'h0;
      bus.ls_wdata_i = 32'h0;
      for (int k = 1; k <= 6; k++) begin
         mid();
         if (k <= 3 && (bus.mem_req_o !== 1'b1 || bus.mem_we_o !== 1'b1 ||
                        bus.mem_addr_o !== 32'h100 || bus.mem_wdata_o !== 32'hDEAD_BEEF)) hold_bad++;
         if (bus.ls_valid_o === 1'b1) begin
            pulses++;
            vcyc = k;
         end
         tick();
      end
      n_checks++;
      if (hold_bad != 0) begin
         n_fail++;
         $display("FAIL store_hold: got %0d cycles with wrong mem outputs required 0", hold_bad);
      end
      n_checks++;
      if (pulses != 1 || vcyc != 4) begin
         n_fail++;
         $display("FAIL store_valid: got %0d pulses at cycle %0d required 1 at cycle 4", pulses, vcyc);
      end
      n_checks++;
      if (bus.ls_rdata_o !== exp_ls_rd) begin
         n_fail++;
         $display("FAIL store_rdata_kept: got %h required %h", bus.ls_rdata_o, exp_ls_rd);
      end
      n_checks++;
      if (mem_read(32'h100) !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL store_written: got %h required deadbeef", mem_read(32'h100));
      end
   endtask

   task automatic test_flush_inflight();
      int vseen  = 0;
      int rd_bad = 0;
      mem_model[32'h500] = 32'h5555_5555;
      mem_lat = 2;
      tick();
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h500;
      mid();
      n_checks++;
      if (bus.if_gnt_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_fetch_gnt: got %b required 1", bus.if_gnt_o);
      end
      tick();
      bus.if_req_i = 1'b0;
      bus.flush_i  = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      mem_lat     = 1;
      for (int k = 3; k <= 7; k++) begin
         mid();
         if (bus.if_valid_o !== 1'b0) vseen++;
         if (bus.if_rdata_o !== exp_if_rd) rd_bad++;
         tick();
      end
      n_checks++;
      if (vseen != 0) begin
         n_fail++;
         $display("FAIL flush_no_valid: got %0d valid cycles required 0", vseen);
      end
      n_checks++;
      if (rd_bad != 0 || bus.if_rdata_o !== exp_if_rd) begin
         n_fail++;
         $display("FAIL flush_rdata_kept: got %h required %h", bus.if_rdata_o, exp_if_rd);
      end
      n_checks++;
      if (bus.mem_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_access_done: got mem_req=%b required 0", bus.mem_req_o);
      end
      bus.if_req_i = 1'b1;
      mid();
      n_checks++;
      if (bus.if_gnt_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_regrant: got %b required 1", bus.if_gnt_o);
      end
      tick();
      bus.if_req_i = 1'b0;
      tick(); tick();
      mid();
      n_checks++;
      if (bus.if_valid_o !== 1'b1 || bus.if_rdata_o !== 32'h5555_5555) begin
         n_fail++;
         $display("FAIL flush_refetch: got valid=%b rdata=%h required 1/55555555", bus.if_valid_o, bus.if_rdata_o);
      end
      exp_if_rd = 32'h5555_5555;
      tick();
   endtask

   task automatic test_flush_idle();
      mem_model[32'h600] = 32'h6060_6060;
      mem_lat = 1;
      tick();
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h600;
      bus.flush_i   = 1'b1;
      mid();
      n_checks++;
      if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_idle_block: got if/ls=%b required 00", {bus.if_gnt_o, bus.ls_gnt_o});
      end
      tick();
      bus.flush_i = 1'b0;
      mid();
      n_checks++;
      if (bus.if_gnt_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_idle_gnt: got %b required 1", bus.if_gnt_o);
      end
      tick();
      bus.if_req_i = 1'b0;
      tick(); tick();
      mid();
      n_checks++;
      if (bus.if_valid_o !== 1'b1 || bus.if_rdata_o !== 32'h6060_6060) begin
         n_fail++;
         $display("FAIL flush_idle_data: got valid=%b rdata=%h required 1/60606060", bus.if_valid_o, bus.if_rdata_o);
      end
      exp_if_rd = 32'h6060_6060;
      tick();
   endtask

   task automatic test_async_reset();
      int vs = 0;
      mem_model[32'h700] = 32'h7070_7070;
      mem_lat = 6;
      tick();
      bus.ls_req_i  = 1'b1;
      bus.ls_we_i   = 1'b0;
      bus.ls_addr_i = 32'h700;
      mid();
      n_checks++;
      if (bus.ls_gnt_o !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_gnt: got %b required 1", bus.ls_gnt_o);
      end
      tick();
      bus.ls_req_i = 1'b0;
      tick();
      mid();
      #2;
      rst_n        = 1'b0;
      bus.if_req_i = 1'b1;
      bus.ls_req_i = 1'b1;
      mem_lat      = 1;
      #1;
      n_checks++;
      if ({bus.mem_req_o, bus.if_gnt_o, bus.ls_gnt_o, bus.ls_valid_o, bus.mem_addr_o, bus.ls_rdata_o, bus.if_rdata_o} !== '0) begin
         n_fail++;
         $display("FAIL areset_immediate: got req=%b gnt=%b%b lsv=%b addr=%h lsrd=%h ifrd=%h required all 0",
                  bus.mem_req_o, bus.if_gnt_o, bus.ls_gnt_o, bus.ls_valid_o, bus.mem_addr_o,
                  bus.ls_rdata_o, bus.if_rdata_o);
      end
      bus.if_req_i = 1'b0;
      bus.ls_req_i = 1'b0;
      mid();
      rst_n     = 1'b1;
      exp_if_rd = '0;
      exp_ls_rd = '0;
      for (int k = 0; k < 8; k++) begin
         tick();
         mid();
         if (bus.ls_valid_o !== 1'b0 || bus.if_valid_o !== 1'b0 || bus.mem_req_o !== 1'b0) vs++;
      end
      n_checks++;
      if (vs != 0) begin
         n_fail++;
         $display("FAIL areset_no_valid: got %0d active cycles after reset required 0", vs);
      end
      tick();
      bus.ls_req_i = 1'b1;
      mid();
      n_checks++;
      if (bus.ls_gnt_o !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_regrant: got %b required 1", bus.ls_gnt_o);
      end
      tick();
      bus.ls_req_i = 1'b0;
      tick(); tick();
      mid();
      n_checks++;
      if (bus.ls_valid_o !== 1'b1 || bus.ls_rdata_o !== 32'h7070_7070 || bus.if_rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL areset_reload: got valid=%b lsrd=%h ifrd=%h required 1/70707070/00000000",
                  bus.ls_valid_o, bus.ls_rdata_o, bus.if_rdata_o);
      end
      exp_ls_rd = 32'h7070_7070;
      tick();
   endtask

   // Reference model tracks one outstanding transaction and the arbitration history only.
   task automatic test_random();
      logic        m_busy = 1'b0, m_ls = 1'b0, m_kill = 1'b0, m_we = 1'b0;
      logic [31:0] m_addr = '0, m_wdata = '0;
      int          m_lost = 0;
`ifdef MEM_ARB_RR_EN
      logic        m_last_ls = 1'b1;
`endif
      logic        e_ifv = 1'b0, e_lsv = 1'b0, e_if_gnt, e_ls_gnt, if_el, ls_el;
      logic        prev_if_gnt = 1'b0, prev_ls_gnt = 1'b0;
      logic [31:0] e_if_rd = exp_if_rd, e_ls_rd = exp_ls_rd;
      for (int c = 0; c < 3000; c++) begin
         if (bus.if_req_i) begin
            if (prev_if_gnt) begin
               bus.if_req_i  = ($urandom_range(0, 99) < 60);
               bus.if_addr_i = 32'($urandom_range(0, 15)) << 2;
            end else if ($urandom_range(0, 99) < 3) bus.if_req_i = 1'b0;
         end else if ($urandom_range(0, 99) < 40) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = 32'($urandom_range(0, 15)) << 2;
         end
         if (bus.ls_req_i && !prev_ls_gnt) begin
            if ($urandom_range(0, 99) < 3) bus.ls_req_i = 1'b0;
         end else if ((bus.ls_req_i && prev_ls_gnt) || $urandom_range(0, 99) < 40) begin
            bus.ls_req_i   = ($urandom_range(0, 99) < 60);
            bus.ls_we_i    = $urandom_range(0, 1) == 1;
            bus.ls_addr_i  = 32'($urandom_range(0, 15)) << 2;
            bus.ls_wdata_i = $urandom;
         end
         bus.flush_i = ($urandom_range(0, 99) < 8);
         mem_lat     = $urandom_range(0, 3);
         mid();

         e_if_gnt = 1'b0;
         e_ls_gnt = 1'b0;
         if (!m_busy) begin
            if_el = bus.if_req_i && !bus.flush_i;
            ls_el = bus.ls_req_i;
            if (if_el && ls_el) begin
`ifdef MEM_ARB_RR_EN
               e_if_gnt = m_last_ls;
`else
               e_if_gnt = (m_lost >= MAX_WAIT);
`endif
               e_ls_gnt = !e_if_gnt;
            end else begin
               e_if_gnt = if_el;
               e_ls_gnt = ls_el;
            end
         end
         n_checks++;
         if ({bus.if_gnt_o, bus.ls_gnt_o} !== {e_if_gnt, e_ls_gnt}) begin
            n_fail++;
            $display("FAIL rand_gnt cycle %0d: got if/ls=%b%b required %b%b", c, bus.if_gnt_o, bus.ls_gnt_o, e_if_gnt, e_ls_gnt);
         end
         n_checks++;
         if ({bus.if_valid_o, bus.ls_valid_o} !== {e_ifv, e_lsv}) begin
            n_fail++;
            $display("FAIL rand_valid cycle %0d: got if/ls=%b%b required %b%b", c, bus.if_valid_o, bus.ls_valid_o, e_ifv, e_lsv);
         end
         n_checks++;
         if (bus.if_rdata_o !== e_if_rd || bus.ls_rdata_o !== e_ls_rd) begin
            n_fail++;
            $display("FAIL rand_rdata cycle %0d: got if=%h ls=%h required if=%h ls=%h", c, bus.if_rdata_o, bus.ls_rdata_o, e_if_rd, e_ls_rd);
         end
         n_checks++;
         if (bus.mem_req_o !== m_busy) begin
            n_fail++;
            $display("FAIL rand_mem_req cycle %0d: got %b required %b", c, bus.mem_req_o, m_busy);
         end
         if (m_busy) begin
            n_checks++;
            if (bus.mem_addr_o !== m_addr || bus.mem_we_o !== m_we || (m_we && bus.mem_wdata_o !== m_wdata)) begin
               n_fail++;
               $display("FAIL rand_mem_bus cycle %0d: got addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                        c, bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o, m_addr, m_we, m_wdata);
            end
         end

         e_ifv = 1'b0;
         e_lsv = 1'b0;
         if (m_busy) begin
            if (!m_ls && bus.flush_i) m_kill = 1'b1;
            if (bus.mem_ack_i) begin
               m_busy = 1'b0;
               if (m_ls) begin
                  e_lsv = 1'b1;
                  if (!m_we) e_ls_rd = bus.mem_rdata_i;
               end else if (!m_kill) begin
                  e_ifv   = 1'b1;
                  e_if_rd = bus.mem_rdata_i;
               end
            end
         end else if (e_if_gnt || e_ls_gnt) begin
            m_busy  = 1'b1;
            m_ls    = e_ls_gnt;
            m_kill  = 1'b0;
            m_addr  = e_ls_gnt ? bus.ls_addr_i : bus.if_addr_i;
            m_we    = e_ls_gnt && bus.ls_we_i;
            m_wdata = bus.ls_wdata_i;
         end
         if (!bus.if_req_i || e_if_gnt) m_lost = 0;
         else if (e_ls_gnt && !bus.flush_i) m_lost++;
`ifdef MEM_ARB_RR_EN
         if (e_if_gnt) m_last_ls = 1'b0;
         else if (e_ls_gnt) m_last_ls = 1'b1;
`endif
         prev_if_gnt = e_if_gnt;
         prev_ls_gnt = e_ls_gnt;
         tick();
      end
      bus.if_req_i = 1'b0;
      bus.ls_req_i = 1'b0;
      bus.flush_i  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lone_fetch();
      test_collision();
      test_store();
      test_flush_inflight();
      test_flush_idle();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
